// File: rtl/sti_pkg.sv
// Shared types for the STI load scheduler: length codes, the queued command
// word, the scheduler state encoding and the length-to-bit-count helper.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  length;
    logic        fill;
    logic        msb;
    logic        low;
  } sti_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SHIFT, S_GAP, S_END, S_DONE
  } sti_state_t;

  function automatic logic [5:0] len_to_bits(input logic [1:0] len);
    logic [2:0] n;
    n = {1'b0, len} + 3'd1;
    return {n, 3'b000};
  endfunction

endpackage

// File: rtl/sti_cmd_fifo.sv
// Small synchronous command FIFO; head is the oldest entry, valid while !empty.
module sti_cmd_fifo
  import sti_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  sti_cmd_t                 din,
  output sti_cmd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  sti_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sti_load_sched.sv
// Command scheduler in front of the STI serializer: queues host commands and
// issues each as a one-cycle load once the previous one has shifted out.
module sti_load_sched
  import sti_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_data,
  input  logic [1:0]               cmd_length,
  input  logic                     cmd_fill,
  input  logic                     cmd_msb,
  input  logic                     cmd_low,
  input  logic                     end_req,
  output logic                     load,
  output logic [15:0]              pi_data,
  output logic [1:0]               pi_length,
  output logic                     pi_fill,
  output logic                     pi_msb,
  output logic                     pi_low,
  output logic                     pi_end,
  input  logic                     so_valid,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int GAP_CYC = (GAP < 1) ? 1 : GAP;
  localparam int GCW     = $clog2(GAP_CYC) + 1;
  localparam int WW      = $clog2(TIMEOUT) + 1;

  sti_state_t      state, next_state;
  sti_cmd_t        head;
  logic            full, empty, push, end_pend;
  logic [5:0]      bit_cnt;
  logic [WW-1:0]   wd_cnt;
  logic [GCW-1:0]  gap_cnt;
  logic            last_bit, wd_expired, gap_done;

  assign cmd_ready  = !full && !end_pend && (state != S_DONE);
  assign push       = cmd_valid && cmd_ready;
  assign last_bit   = so_valid && (bit_cnt == 6'd1);
  assign wd_expired = !so_valid && (wd_cnt == WW'(TIMEOUT - 1));
  assign gap_done   = (gap_cnt == GCW'(GAP_CYC - 1));

  sti_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (state == S_ISSUE),
    .din   ({cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // A queued command leaves GAP straight for ISSUE so the next load lands
  // exactly GAP+1 cycles after the final so_valid.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (!empty)        next_state = S_ISSUE;
               else if (end_pend) next_state = S_END;
      S_ISSUE: next_state = S_SHIFT;
      S_SHIFT: if (last_bit || wd_expired) next_state = S_GAP;
      S_GAP:   if (gap_done) next_state = empty ? S_IDLE : S_ISSUE;
      S_END:   next_state = S_DONE;
      S_DONE:  next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    load   = (state == S_ISSUE);
    pi_end = (state == S_END);
    busy   = (state != S_IDLE) && (state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {pi_data, pi_length, pi_fill, pi_msb, pi_low} <= '0;
      bit_cnt     <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      end_pend    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (next_state == S_ISSUE)
        {pi_data, pi_length, pi_fill, pi_msb, pi_low} <= head;
      if (end_req && state != S_DONE) end_pend <= 1'b1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (state == S_ISSUE) begin
        bit_cnt <= len_to_bits(pi_length);
        wd_cnt  <= '0;
      end else if (state == S_SHIFT) begin
        if (so_valid) begin
          bit_cnt <= bit_cnt - 1'b1;
          wd_cnt  <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
        if (wd_expired) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sti_load_sched.sv
// Randomized bench for sti_load_sched: a serializer model answers each load,
// and a transaction-level timing model predicts every output cycle by cycle.
module tb_sti_load_sched;
  import sti_pkg::*;

  localparam int DEPTH = 4, GAP = 2, TIMEOUT = 64;
  localparam int GAPC  = (GAP < 1) ? 1 : GAP;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [1:0]  cmd_length = '0;
  logic cmd_fill = 1'b0, cmd_msb = 1'b0, cmd_low = 1'b0, end_req = 1'b0;
  logic load, pi_fill, pi_msb, pi_low, pi_end, so_valid = 1'b0, busy, timeout_err;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic [$clog2(DEPTH):0] fifo_count;

  sti_load_sched #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_length(cmd_length), .cmd_fill(cmd_fill),
    .cmd_msb(cmd_msb), .cmd_low(cmd_low), .end_req(end_req), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .so_valid(so_valid),
    .busy(busy), .timeout_err(timeout_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { sti_cmd_t c; int pc; } ent_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  ent_t q[$];
  int ready_cyc, ep_from, end_cyc, terr_from, inflight;
  sti_cmd_t last_pi;
  int ld_cyc, nbits, sent, stall_at, zeros_left, last_act;
  int p_valid, p_stall, p_noise, force_len;
  bit want_end, fix_en;
  sti_cmd_t fix_cmd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_model();
    q.delete();
    ready_cyc = cyc; ep_from = -1; end_cyc = -1; terr_from = -1;
    inflight = 0; last_pi = '0; want_end = 0; fix_en = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; end_req = 1'b0; so_valid = 1'b0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // One cycle: check outputs against the model, then drive this cycle's inputs.
  task automatic step();
    bit done, exp_load, exp_rdy, sv;
    sti_cmd_t c;
    done     = (end_cyc >= 0) && (cyc > end_cyc);
    exp_load = 0;
    if (!inflight && q.size() > 0 && !done)
      exp_load = (cyc == imax(q[0].pc + 2, ready_cyc));
    exp_rdy = (q.size() < DEPTH) && !(ep_from >= 0 && cyc >= ep_from) && !done;
    chk("load", 32'(load), 32'(exp_load));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(inflight != 0 || cyc < ready_cyc || cyc == end_cyc || exp_load));
    chk("pi_end", 32'(pi_end), 32'(cyc == end_cyc));
    chk("timeout_err", 32'(timeout_err), 32'(terr_from >= 0 && cyc >= terr_from));
    if (exp_load) begin
      last_pi = q[0].c;
      void'(q.pop_front());
      inflight = 1; ld_cyc = cyc; last_act = cyc; sent = 0;
      nbits = (int'(last_pi.length) + 1) * 8;
      stall_at = ($urandom_range(0, 99) < p_stall) ? int'($urandom_range(0, nbits - 1)) : -1;
      zeros_left = $urandom_range(0, 3);
    end
    chk("pi_fields", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'(last_pi));

    sv = 0;
    if (inflight && cyc > ld_cyc) begin
      if (sent == stall_at) begin
        if (cyc == last_act + TIMEOUT) begin
          inflight = 0; ready_cyc = cyc + GAPC + 1;
          if (terr_from < 0) terr_from = cyc + 1;
        end
      end else if (zeros_left > 0) begin
        zeros_left--;
      end else begin
        sv = 1; sent++; last_act = cyc; zeros_left = $urandom_range(0, 2);
        if (sent == nbits) begin inflight = 0; ready_cyc = cyc + GAPC + 1; end
      end
    end else if (!inflight) begin
      sv = ($urandom_range(0, 99) < p_noise);
    end
    so_valid = sv;

    end_req = 1'b0;
    if (want_end) begin
      end_req = 1'b1; want_end = 0;
      if (!done && ep_from < 0) ep_from = cyc + 1;
    end

    c.data   = 16'($urandom);
    c.length = (force_len >= 0) ? 2'(force_len) : 2'($urandom_range(0, 3));
    c.fill   = 1'($urandom); c.msb = 1'($urandom); c.low = 1'($urandom);
    cmd_valid = ($urandom_range(0, 99) < p_valid);
    if (fix_en) begin c = fix_cmd; cmd_valid = 1'b1; end
    {cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low} = c;
    if (cmd_valid && exp_rdy) begin
      q.push_back('{c, cyc});
      fix_en = 0;
    end

    if (ep_from >= 0 && end_cyc < 0 && q.size() == 0 && !inflight)
      end_cyc = imax(ready_cyc, ep_from) + 1;

    @(posedge clk); cyc++; #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int v, input int s, input int nz, input int fl);
    p_valid = v; p_stall = s; p_noise = nz; force_len = fl;
  endtask

  initial begin
    knobs(0, 0, 0, -1);
    do_reset();

    // single 16b command A5C3, MSB-first
    fix_cmd = '{data: 16'hA5C3, length: LEN_16, fill: 1'b0, msb: 1'b1, low: 1'b0};
    fix_en = 1;
    run(80);

    // mixed traffic, then with serializer stalls and stray so_valid
    knobs(60, 0, 20, -1); run(400);
    knobs(40, 30, 25, -1); run(900);

    // end request with commands still queued
    knobs(100, 0, 0, -1);
    for (int i = 0; i < 50 && q.size() < 2; i++) step();
    chk("end_setup_queued", 32'(q.size() >= 2), 32'd1);
    want_end = 1;
    knobs(50, 0, 10, -1); run(300);
    chk("end_reached", 32'(end_cyc >= 0 && cyc > end_cyc), 32'd1);
    do_reset();

    // end request on an idle, empty scheduler; DONE ignores later commands
    knobs(0, 0, 0, -1); run(5);
    want_end = 1; run(20);
    knobs(100, 0, 0, -1); run(20);
    do_reset();

    // reset in the middle of a 32b shift with three commands waiting
    knobs(100, 0, 0, LEN_32);
    for (int i = 0; i < 300 && !(inflight && cyc > ld_cyc + 5 && q.size() >= 3); i++) step();
    chk("midshift_setup", 32'(inflight != 0 && q.size() >= 3), 32'd1);
    do_reset();
    knobs(0, 0, 20, -1); run(60);

    // random rounds, each closed by an end request and a reset
    for (int r = 0; r < 4; r++) begin
      knobs($urandom_range(10, 90), $urandom_range(0, 40), $urandom_range(0, 30), -1);
      run(350);
      want_end = 1;
      run(250);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
